// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: after a debounced go edge, walks a fixed table of
// (sub, data) register writes and hands each entry to I2C_master as one
// transaction. It reports progress, completion and handshake timeouts.
module i2c_init_sequencer #(
    parameter logic [6:0] DEV_ADDR    = 7'b1101000,
    parameter int         NUM_WRITES  = 4,
    parameter int         TIMEOUT     = 100000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       ready,
    input  logic       done,
    output logic [6:0] addr,
    output logic [7:0] sub,
    output logic [7:0] data,
    output logic       start,
    output logic       busy,
    output logic       complete,
    output logic       error,
    output logic [1:0] index
);

    localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       LAST_INDEX = 2'(NUM_WRITES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT,
        FINISH,
        ERROR
    } state_t;

    state_t                 state, state_nxt;
    logic                   start_nxt, busy_nxt, complete_nxt, error_nxt;
    logic [1:0]             index_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, cnt_inc;
    logic [SYNC_STAGES-1:0] go_sync;
    logic                   go_prev;
    logic                   go_rise;

    // Bring the asynchronous go level into clk and remember its last value for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            go_sync <= '0;
            go_prev <= 1'b0;
        end else begin
            go_sync[0] <= go;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                go_sync[i] <= go_sync[i-1];
            end
            go_prev <= go_sync[SYNC_STAGES-1];
        end
    end

    assign go_rise = go_sync[SYNC_STAGES-1] & ~go_prev;

    // The counter saturates so a handshake landing on the final budget cycle still leaves no slack in WAIT_DONE
    assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);

    // State register plus the registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            start    <= 1'b0;
            busy     <= 1'b0;
            complete <= 1'b0;
            error    <= 1'b0;
            index    <= 2'd0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            start    <= start_nxt;
            busy     <= busy_nxt;
            complete <= complete_nxt;
            error    <= error_nxt;
            index    <= index_nxt;
            cnt      <= cnt_nxt;
        end
    end

    // Sequencing: issue each entry, follow the master handshake, and abort when the per-entry budget runs out
    always_comb begin
        state_nxt    = state;
        start_nxt    = start;
        busy_nxt     = busy;
        complete_nxt = complete;
        error_nxt    = error;
        index_nxt    = index;
        cnt_nxt      = cnt;
        case (state)
            IDLE, FINISH, ERROR: begin
                if (go_rise) begin
                    state_nxt    = ISSUE;
                    complete_nxt = 1'b0;
                    error_nxt    = 1'b0;
                    index_nxt    = 2'd0;
                    busy_nxt     = 1'b1;
                    start_nxt    = 1'b0;
                end
            end
            ISSUE: begin
                if (ready) begin
                    start_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!ready) begin
                    start_nxt = 1'b0;
                    cnt_nxt   = cnt_inc;
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    start_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    error_nxt = 1'b1;
                    state_nxt = ERROR;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    state_nxt = NEXT;
                end else if (cnt == CNT_LAST) begin
                    start_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    error_nxt = 1'b1;
                    state_nxt = ERROR;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            NEXT: begin
                if (index == LAST_INDEX) begin
                    busy_nxt     = 1'b0;
                    complete_nxt = 1'b1;
                    state_nxt    = FINISH;
                end else if (!done && ready) begin
                    index_nxt = index + 2'd1;
                    state_nxt = ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign addr = DEV_ADDR;

    // Fixed register table; index only moves in NEXT so sub/data hold for a whole transaction
    always_comb begin
        sub  = 8'h20;
        data = 8'h0F;
        case (index)
            2'd0: begin sub = 8'h20; data = 8'h0F; end
            2'd1: begin sub = 8'h21; data = 8'h00; end
            2'd2: begin sub = 8'h22; data = 8'h08; end
            2'd3: begin sub = 8'h23; data = 8'h30; end
            default: begin sub = 8'h20; data = 8'h0F; end
        endcase
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: drives the sequencer against a behavioural I2C master
// and compares the logged transactions and status flags with a table model.
module tb_i2c_init_sequencer;

    localparam int         TIMEOUT_TB  = 200;
    localparam int         SYNC_TB     = 2;
    localparam int         HANG_CYCLES = 300;
    localparam logic [6:0] DEV         = 7'h68;

    logic       clk;
    logic       reset;
    logic       go, ready, done;
    logic [6:0] addr;
    logic [7:0] sub, data;
    logic       start, busy, complete, error;
    logic [1:0] index;
    logic       go1, ready1, done1;
    logic [6:0] addr1;
    logic [7:0] sub1, data1;
    logic       start1, busy1, complete1, error1;
    logic [1:0] index1;

    int   vectors      = 0;
    int   miscompares  = 0;
    int   cyc          = 0;
    int   start_rises  = 0;
    int   start1_rises = 0;
    logic start_q      = 1'b0;
    logic start1_q     = 1'b0;
    int   go_cyc       = 0;

    int   acc_dly   = 3;
    int   done_dly  = 50;
    int   hang_txn  = -1;
    int   tie_txn   = -1;
    int   tie_extra = 0;
    int   txn_count = 0;
    bit   master_idle;
    int         start_cyc_q[$];
    logic [6:0] addr_q[$];
    logic [7:0] sub_q[$];
    logic [7:0] data_q[$];

    i2c_init_sequencer #(.DEV_ADDR(DEV), .NUM_WRITES(4), .TIMEOUT(TIMEOUT_TB), .SYNC_STAGES(SYNC_TB)) dut (
        .clk(clk), .reset(reset), .go(go), .ready(ready), .done(done),
        .addr(addr), .sub(sub), .data(data), .start(start), .busy(busy),
        .complete(complete), .error(error), .index(index)
    );

    i2c_init_sequencer #(.DEV_ADDR(DEV), .NUM_WRITES(1), .TIMEOUT(TIMEOUT_TB), .SYNC_STAGES(SYNC_TB)) dut1 (
        .clk(clk), .reset(reset), .go(go1), .ready(ready1), .done(done1),
        .addr(addr1), .sub(sub1), .data(data1), .start(start1), .busy(busy1),
        .complete(complete1), .error(error1), .index(index1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and start-pulse counters for both instances
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        start_q  <= start;
        start1_q <= start1;
        if (start === 1'b1 && start_q !== 1'b1) start_rises <= start_rises + 1;
        if (start1 === 1'b1 && start1_q !== 1'b1) start1_rises <= start1_rises + 1;
    end

    // Reference table: sub-addresses count up from 0x20, data comes from a fixed list
    function automatic logic [7:0] model_sub(input int i);
        return 8'h20 + 8'(i);
    endfunction

    function automatic logic [7:0] model_data(input int i);
        logic [7:0] tbl [4];
        tbl = '{8'h0F, 8'h00, 8'h08, 8'h30};
        if (i < 0 || i > 3) return 8'hxx;
        return tbl[i];
    endfunction

    // Behavioural I2C master: accepts start after acc_dly cycles, finishes after a delay, logs what it was asked to write
    initial begin : master_model
        int cur;
        int dly;
        ready = 1'b1;
        done = 1'b0;
        master_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (start === 1'b1 && reset !== 1'b1) begin
                master_idle = 1'b0;
                cur = txn_count;
                txn_count++;
                start_cyc_q.push_back(cyc);
                repeat (acc_dly - 1) @(negedge clk);
                ready = 1'b0;
                addr_q.push_back(addr);
                sub_q.push_back(sub);
                data_q.push_back(data);
                if (cur == hang_txn) begin
                    repeat (HANG_CYCLES) @(negedge clk);
                end else begin
                    dly = (cur == tie_txn) ? (TIMEOUT_TB - acc_dly + tie_extra) : done_dly;
                    repeat (dly) @(negedge clk);
                    done = 1'b1;
                    @(negedge clk);
                end
                done = 1'b0;
                ready = 1'b1;
                master_idle = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_log();
        txn_count = 0;
        start_cyc_q.delete();
        addr_q.delete();
        sub_q.delete();
        data_q.delete();
    endtask

    task automatic press_go(input bit sel, input int hold);
        @(negedge clk);
        go_cyc = cyc;
        #($urandom_range(0, 3));
        if (sel) go1 = 1'b1; else go = 1'b1;
        repeat (hold) @(negedge clk);
        if (sel) go1 = 1'b0; else go = 1'b0;
    endtask

    task automatic wait_idle(output bit expired);
        expired = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && master_idle) begin
                expired = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({start, busy, complete, error} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, want 0000", {start, busy, complete, error});
        end
        vectors++;
        if ({addr, index, sub, data} !== {DEV, 2'd0, model_sub(0), model_data(0)}) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h/%0d/%h/%h, want %h/0/%h/%h",
                     addr, index, sub, data, DEV, model_sub(0), model_data(0));
        end
        vectors++;
        if ({start1, busy1, complete1, error1, index1} !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut1: got %b, want 000000", {start1, busy1, complete1, error1, index1});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_sequence();
        int  base;
        int  lat;
        bit  expired;
        for (int it = 0; it < 3; it++) begin
            acc_dly  = $urandom_range(1, 5);
            done_dly = $urandom_range(5, 60);
            clear_log();
            base = start_rises;
            press_go(1'b0, $urandom_range(4, 6));
            wait_idle(expired);
            vectors++;
            if (expired) begin
                miscompares++;
                $display("[TB] FAIL full_idle_wait: got timeout, want sequence end (iter %0d)", it);
            end
            vectors++;
            if (sub_q.size() != 4 || start_rises - base != 4) begin
                miscompares++;
                $display("[TB] FAIL full_count: got %0d txns/%0d starts, want 4/4", sub_q.size(), start_rises - base);
            end
            foreach (sub_q[i]) begin
                vectors++;
                if ({addr_q[i], sub_q[i], data_q[i]} !== {DEV, model_sub(i), model_data(i)}) begin
                    miscompares++;
                    $display("[TB] FAIL full_txn%0d: got %h/%h/%h, want %h/%h/%h",
                             i, addr_q[i], sub_q[i], data_q[i], DEV, model_sub(i), model_data(i));
                end
            end
            lat = (start_cyc_q.size() > 0) ? start_cyc_q[0] - go_cyc : -1;
            vectors++;
            if (lat < SYNC_TB + 2 || lat > SYNC_TB + 3) begin
                miscompares++;
                $display("[TB] FAIL full_go_latency: got %0d, want %0d..%0d", lat, SYNC_TB + 2, SYNC_TB + 3);
            end
            vectors++;
            if ({complete, busy, error, index} !== {1'b1, 1'b0, 1'b0, 2'd3}) begin
                miscompares++;
                $display("[TB] FAIL full_status: got c%b b%b e%b i%0d, want c1 b0 e0 i3", complete, busy, error, index);
            end
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_go_while_busy();
        int base;
        bit expired;
        bit reached;
        acc_dly  = 3;
        done_dly = 50;
        clear_log();
        base = start_rises;
        press_go(1'b0, 4);
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (txn_count >= 2) begin reached = 1'b1; break; end
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("[TB] FAIL busy_reach_entry1: got %0d txns, want 2", txn_count);
        end
        press_go(1'b0, $urandom_range(4, 6));
        wait_idle(expired);
        vectors++;
        if (expired || start_rises - base != 4) begin
            miscompares++;
            $display("[TB] FAIL busy_start_count: got %0d starts (expired %b), want 4", start_rises - base, expired);
        end
        vectors++;
        if ({index, complete, error} !== {2'd3, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL busy_final: got i%0d c%b e%b, want i3 c1 e0", index, complete, error);
        end
        foreach (sub_q[i]) begin
            vectors++;
            if ({sub_q[i], data_q[i]} !== {model_sub(i), model_data(i)}) begin
                miscompares++;
                $display("[TB] FAIL busy_txn%0d: got %h/%h, want %h/%h", i, sub_q[i], data_q[i], model_sub(i), model_data(i));
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout();
        int t0;
        int elapsed;
        bit seen;
        bit expired;
        acc_dly  = $urandom_range(1, 5);
        done_dly = 20;
        hang_txn = 2;
        clear_log();
        press_go(1'b0, 4);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (start_cyc_q.size() >= 3) begin seen = 1'b1; break; end
        end
        t0 = seen ? start_cyc_q[2] : cyc;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (error === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        elapsed = cyc - t0;
        vectors++;
        if (!seen || elapsed < TIMEOUT_TB - 1 || elapsed > TIMEOUT_TB + 1) begin
            miscompares++;
            $display("[TB] FAIL timeout_delay: got %0d cycles (error seen %b), want %0d +/-1", elapsed, seen, TIMEOUT_TB);
        end
        vectors++;
        if ({start, busy, complete, index} !== {1'b0, 1'b0, 1'b0, 2'd2}) begin
            miscompares++;
            $display("[TB] FAIL timeout_status: got s%b b%b c%b i%0d, want s0 b0 c0 i2", start, busy, complete, index);
        end
        for (int i = 0; i < 600 && !master_idle; i++) @(negedge clk);
        hang_txn = -1;
        repeat (3) @(negedge clk);
        clear_log();
        press_go(1'b0, 4);
        vectors++;
        if ({busy, error} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL timeout_restart_clear: got b%b e%b, want b1 e0", busy, error);
        end
        wait_idle(expired);
        vectors++;
        if (expired || sub_q.size() != 4 || {complete, error} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL timeout_restart: got %0d txns c%b e%b, want 4 c1 e0", sub_q.size(), complete, error);
        end
        vectors++;
        if (sub_q.size() == 0 || {sub_q[0], data_q[0]} !== {model_sub(0), model_data(0)}) begin
            miscompares++;
            $display("[TB] FAIL timeout_restart_entry0: got %0d txns, want first %h/%h", sub_q.size(), model_sub(0), model_data(0));
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout_tie();
        bit expired;
        for (int extra = 0; extra < 2; extra++) begin
            acc_dly   = $urandom_range(1, 5);
            done_dly  = $urandom_range(5, 40);
            tie_txn   = 1;
            tie_extra = extra;
            clear_log();
            press_go(1'b0, 4);
            wait_idle(expired);
            vectors++;
            if (expired) begin
                miscompares++;
                $display("[TB] FAIL tie_idle_wait%0d: got timeout, want sequence end", extra);
            end
            vectors++;
            if (extra == 0) begin
                if ({error, complete, index} !== {1'b0, 1'b1, 2'd3} || sub_q.size() != 4) begin
                    miscompares++;
                    $display("[TB] FAIL tie_handshake_wins: got e%b c%b i%0d n%0d, want e0 c1 i3 n4",
                             error, complete, index, sub_q.size());
                end
            end else begin
                if ({error, complete, busy, index} !== {1'b1, 1'b0, 1'b0, 2'd1} || sub_q.size() != 2) begin
                    miscompares++;
                    $display("[TB] FAIL tie_one_late: got e%b c%b b%b i%0d n%0d, want e1 c0 b0 i1 n2",
                             error, complete, busy, index, sub_q.size());
                end
            end
            repeat (5) @(negedge clk);
        end
        tie_txn   = -1;
        tie_extra = 0;
    endtask

    task automatic test_reset_mid_op();
        int base;
        bit reached;
        acc_dly  = 3;
        done_dly = 80;
        clear_log();
        press_go(1'b0, 4);
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (txn_count >= 2 && ready === 1'b0) begin reached = 1'b1; break; end
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_reach: got %0d txns, want entry 1 accepted", txn_count);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({start, busy, complete, error, index} !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_clear: got s%b b%b c%b e%b i%0d, want all 0", start, busy, complete, error, index);
        end
        reset = 1'b0;
        base = start_rises;
        repeat (150) @(negedge clk);
        vectors++;
        if (start_rises != base || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_quiet: got %0d starts b%b, want 0 b0", start_rises - base, busy);
        end
    endtask

    task automatic test_num_writes_one();
        int base;
        bit early;
        ready1 = 1'b0;
        done1  = 1'b0;
        base = start1_rises;
        press_go(1'b1, 4);
        early = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (start1 !== 1'b0) early = 1'b1;
        end
        vectors++;
        if (early || busy1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL one_wait_ready: got early start %b b%b, want 0 b1", early, busy1);
        end
        ready1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (start1 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL one_start_after_ready: got %b, want 1", start1);
        end
        vectors++;
        if ({addr1, sub1, data1} !== {DEV, model_sub(0), model_data(0)}) begin
            miscompares++;
            $display("[TB] FAIL one_txn: got %h/%h/%h, want %h/%h/%h", addr1, sub1, data1, DEV, model_sub(0), model_data(0));
        end
        ready1 = 1'b0;
        @(negedge clk);
        vectors++;
        if (start1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL one_start_drop: got %b, want 0", start1);
        end
        repeat (5) @(negedge clk);
        done1 = 1'b1;
        @(negedge clk);
        done1  = 1'b0;
        ready1 = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({complete1, busy1, error1, index1} !== {1'b1, 1'b0, 1'b0, 2'd0} || start1_rises - base != 1) begin
            miscompares++;
            $display("[TB] FAIL one_final: got c%b b%b e%b i%0d starts %0d, want c1 b0 e0 i0 starts 1",
                     complete1, busy1, error1, index1, start1_rises - base);
        end
    endtask

    initial begin
        reset  = 1'b1;
        go     = 1'b0;
        go1    = 1'b0;
        ready1 = 1'b0;
        done1  = 1'b0;
        test_reset();
        test_full_sequence();
        test_go_while_busy();
        test_timeout();
        test_timeout_tie();
        test_reset_mid_op();
        test_num_writes_one();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Upstream command source for I2C_master: replaces the constant addr/sub/data registers and the raw BTNC start with a sequenced register-write list.
- Runs in the i2c_clk domain, the same clock as I2C_master.
- On a debounced go edge, issues a fixed table of (sub, data) writes to one device address, one I2C transaction per entry.
- Reports progress, completion and timeout errors on LEDs or debug pins.

Parameters:
- DEV_ADDR, 7'b1101000: 7-bit device address driven on addr for every transaction.
- NUM_WRITES, 4: number of table entries issued, legal range 1..4.
- TIMEOUT, 100000: maximum clk cycles spent in WAIT_ACK plus WAIT_DONE for one entry before aborting.
- SYNC_STAGES, 2: synchroniser depth on go.

Ports:
- clk  in  1  i2c_clk, the same clock as I2C_master.
- reset  in  1  synchronous, active-high.
- go  in  1  asynchronous level, e.g. a button; a rising edge starts the sequence.
- ready  in  1  from I2C_master: high when the master is idle and can accept start.
- done  in  1  from I2C_master: high when the current transaction has completed.
- addr  out  7  to I2C_master.
- sub  out  8  register sub-address for the current entry.
- data  out  8  write data for the current entry.
- start  out  1  to I2C_master.
- busy  out  1  high from go acceptance until FINISH or ERROR.
- complete  out  1  sticky; all NUM_WRITES entries were written.
- error  out  1  sticky; a timeout occurred.
- index  out  2  current table entry.

Behaviour:
- Table, fixed:
  - entry 0: sub 0x20, data 0x0F
  - entry 1: sub 0x21, data 0x00
  - entry 2: sub 0x22, data 0x08
  - entry 3: sub 0x23, data 0x30
- sub and data are combinational decodes of index.
- addr is constant DEV_ADDR.
- go path: SYNC_STAGES flops, plus one edge-detect flop. go_rise is high for exactly 1 cycle, SYNC_STAGES+1 cycles after the input rises.
- go_rise is ignored unless the state is IDLE, FINISH or ERROR.
- Reset values: start=0, busy=0, complete=0, error=0, index=0, timeout counter=0, synchroniser flops=0, state=IDLE.
- FSM states and transitions:
  - IDLE: on go_rise, clear complete and error, index←0, busy←1, go to ISSUE.
  - ISSUE: wait for ready=1. In the cycle ready=1 is seen, start←1, cnt←0, go to WAIT_ACK.
  - WAIT_ACK: start stays 1. When ready=0 (master accepted), start←0 and go to WAIT_DONE.
  - WAIT_DONE: on done=1, go to NEXT.
  - NEXT: if index==NUM_WRITES-1, go to FINISH. Otherwise wait for done=0 and ready=1, then index←index+1 and go to ISSUE. That wait does not time out.
  - FINISH: busy←0, complete←1; on go_rise, restart as in IDLE.
  - ERROR: busy←0, start←0, error←1; index holds the failing entry; on go_rise, restart as in IDLE.
- Timeout:
  - cnt increments every cycle in WAIT_ACK and WAIT_DONE.
  - When cnt reaches TIMEOUT-1 without the exit condition, go to ERROR on the next edge.
  - If done=1 or ready=0 arrives in the same cycle as the timeout, the handshake wins.
- start is registered and never high outside WAIT_ACK, except the cycle it is set at the end of ISSUE.
- Minimum latency from go_rise to start=1 (ready already high): 2 cycles (IDLE→ISSUE, ISSUE sets start).
- reset mid-operation: all state returns to reset values on the next edge. start drops immediately; no recovery of the master's bus state is attempted (BTND resets the master at the same time).
- sub and data must stay stable from start=1 until done=1 for that entry, because index only changes in NEXT.
- index width is 2 bits; no wrap-around, because NEXT stops at NUM_WRITES-1.

Test Plan:
- Full sequence: master model with ready high, accepts start after 3 cycles, done after 50 cycles. Pulse go. → 4 transactions with (sub, data) = (20,0F), (21,00), (22,08), (23,30); addr=0x68 each time; complete=1, busy=0, error=0.
- go while busy: second go edge during entry 1. → ignored; exactly 4 start assertions; final index=3.
- Timeout: TIMEOUT=200, master never raises done on entry 2. → error=1 at 200 cycles after entry-2 acceptance (±1); start=0; index=2; busy=0. A subsequent go restarts from entry 0 and clears error.
- Reset mid-operation: assert reset during WAIT_DONE of entry 1. → next edge start=0, busy=0, index=0, complete=0, error=0, state IDLE; no further start without a new go.
- NUM_WRITES=1 and slow ready: ready held low for 10 cycles after go. → start rises only in the cycle after ready rises; single write (20,0F); complete=1.
- Handshake vs. timeout tie: done asserted in exactly the cycle cnt=TIMEOUT-1. → transition to NEXT; error stays 0.
